// File: rtl/ddr_line_fetcher_if.sv
// ddr_if: host-side view of the DDR arbiter port.
//   addr/wdata/read/write/burstcnt/byteenable/acquire : host -> arbiter
//   busy/rdata_ready/rdata                            : arbiter -> host
// addr is a 64-bit word address; burstcnt counts 64-bit words (up to 128).
interface ddr_if;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic        read;
    logic        write;
    logic [7:0]  burstcnt;
    logic [7:0]  byteenable;
    logic        acquire;
    logic        busy;
    logic        rdata_ready;
    logic [63:0] rdata;

    modport to_host (
        output addr, wdata, read, write, burstcnt, byteenable, acquire,
        input  busy, rdata_ready, rdata
    );
endinterface

// File: rtl/ddr_line_fetcher.sv
// ddr_line_fetcher: turns single-cycle client requests into either a LINE_WORDS-word burst
// read (streamed out word by word) or a single-word masked write on a ddr_if port.
// acquire is held for the whole transaction and dropped for one RELEASE cycle afterwards
// so the arbiter can rotate the grant.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   ddr                        : ddr_if host port
//   rd_req, rd_addr            : line-read request (address aligned down to a line)
//   wr_req, wr_addr, wr_data,
//   wr_be                      : single-word write request
//   req_ready                  : idle; a request is taken on this edge
//   out_valid/out_data/
//   out_index/out_last         : read word stream, no backpressure
//   done                       : one-cycle pulse at transaction completion
module ddr_line_fetcher #(
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    ddr_if.to_host      ddr,
    input  logic        rd_req,
    input  logic [31:0] rd_addr,
    input  logic        wr_req,
    input  logic [31:0] wr_addr,
    input  logic [63:0] wr_data,
    input  logic [7:0]  wr_be,
    output logic        req_ready,
    output logic        out_valid,
    output logic [63:0] out_data,
    output logic [((LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1)-1:0] out_index,
    output logic        out_last,
    output logic        done
);

    localparam int unsigned IdxW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    // One extra bit so the counter can reach LINE_WORDS without wrapping.
    localparam int unsigned CntW = $clog2(LINE_WORDS) + 1;
    localparam logic [31:0] AlignMask = ~32'(LINE_WORDS - 1);

    typedef enum logic [2:0] {StIdle, StRdCmd, StRdData, StWrCmd, StRelease} state_e;

    state_e state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0] be_q, be_d;
    logic [CntW-1:0] beat_q, beat_d;

    logic rd_strobe, wr_strobe, acq;
    logic [7:0] burst, be_out;
    logic last_beat;

    assign last_beat = (beat_q == CntW'(LINE_WORDS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        beat_d    = beat_q;
        req_ready = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        rd_strobe = 1'b0;
        wr_strobe = 1'b0;
        acq       = 1'b0;
        burst     = '0;
        be_out    = '0;
        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                // Read has priority; a concurrent write stays pending at the client.
                if (rd_req) begin
                    addr_d  = rd_addr & AlignMask;
                    beat_d  = '0;
                    state_d = StRdCmd;
                end else if (wr_req) begin
                    addr_d  = wr_addr;
                    wdata_d = wr_data;
                    be_d    = wr_be;
                    state_d = StWrCmd;
                end
            end
            StRdCmd: begin
                acq       = 1'b1;
                rd_strobe = 1'b1;
                burst     = 8'(LINE_WORDS);
                if (!ddr.busy) state_d = StRdData;
            end
            StRdData: begin
                acq = 1'b1;
                // busy is irrelevant here; beats are collected whenever they arrive.
                if (ddr.rdata_ready) begin
                    out_valid = 1'b1;
                    beat_d    = beat_q + 1'b1;
                    if (last_beat) begin
                        done    = 1'b1;
                        state_d = StRelease;
                    end
                end
            end
            StWrCmd: begin
                acq       = 1'b1;
                wr_strobe = 1'b1;
                burst     = 8'd1;
                be_out    = be_q;
                if (!ddr.busy) begin
                    done    = 1'b1;
                    state_d = StRelease;
                end
            end
            StRelease: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign out_data  = out_valid ? ddr.rdata : '0;
    assign out_index = out_valid ? beat_q[IdxW-1:0] : '0;
    assign out_last  = out_valid & last_beat;

    assign ddr.addr       = addr_q;
    assign ddr.wdata      = wdata_q;
    assign ddr.read       = rd_strobe;
    assign ddr.write      = wr_strobe;
    assign ddr.burstcnt   = burst;
    assign ddr.byteenable = be_out;
    assign ddr.acquire    = acq;

endmodule

// File: tb/tb_ddr_line_fetcher.sv
module tb_ddr_line_fetcher;

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  idx;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Client-side stimulus, instance 0 and 1.
    logic        rd_req0 = 0, rd_req1 = 0, wr_req0 = 0, wr_req1 = 0;
    logic [31:0] rd_addr0 = 0, rd_addr1 = 0, wr_addr0 = 0, wr_addr1 = 0;
    logic [63:0] wr_data0 = 0, wr_data1 = 0;
    logic [7:0]  wr_be0 = 0, wr_be1 = 0;
    logic        req_ready0, out_valid0, out_last0, done0;
    logic        req_ready1, out_valid1, out_last1, done1;
    logic [63:0] out_data0, out_data1;
    logic [1:0]  out_index0, out_index1;

    // Memory / arbiter side.
    logic        use_arb = 0;
    logic        busy_mem = 0;
    logic        rdr0 = 0, rdr1 = 0;
    logic [63:0] rdata0 = 0, rdata1 = 0;
    logic [1:0]  grant_q, last_q;

    ddr_if d0 ();
    ddr_if d1 ();

    assign d0.busy        = use_arb ? (grant_q != 2'd1) : busy_mem;
    assign d1.busy        = use_arb ? (grant_q != 2'd2) : 1'b1;
    assign d0.rdata_ready = rdr0;
    assign d1.rdata_ready = rdr1;
    assign d0.rdata       = rdata0;
    assign d1.rdata       = rdata1;

    ddr_line_fetcher #(.LINE_WORDS(4)) u_dut0 (
        .clk(clk), .reset(reset), .ddr(d0),
        .rd_req(rd_req0), .rd_addr(rd_addr0),
        .wr_req(wr_req0), .wr_addr(wr_addr0), .wr_data(wr_data0), .wr_be(wr_be0),
        .req_ready(req_ready0), .out_valid(out_valid0), .out_data(out_data0),
        .out_index(out_index0), .out_last(out_last0), .done(done0)
    );

    ddr_line_fetcher #(.LINE_WORDS(4)) u_dut1 (
        .clk(clk), .reset(reset), .ddr(d1),
        .rd_req(rd_req1), .rd_addr(rd_addr1),
        .wr_req(wr_req1), .wr_addr(wr_addr1), .wr_data(wr_data1), .wr_be(wr_be1),
        .req_ready(req_ready1), .out_valid(out_valid1), .out_data(out_data1),
        .out_index(out_index1), .out_last(out_last1), .done(done1)
    );

    // Two ports of a grant-holding arbiter: grants one edge after seeing acquire,
    // holds while acquire stays high, alternates when both are waiting.
    always @(posedge clk) begin
        if (reset) begin
            grant_q <= 2'd0;
            last_q  <= 2'd2;
        end else if ((grant_q == 2'd1 && !d0.acquire) || (grant_q == 2'd2 && !d1.acquire)) begin
            grant_q <= 2'd0;
        end else if (grant_q == 2'd0) begin
            if (d0.acquire && (!d1.acquire || last_q == 2'd2)) begin
                grant_q <= 2'd1;
                last_q  <= 2'd1;
            end else if (d1.acquire) begin
                grant_q <= 2'd2;
                last_q  <= 2'd2;
            end
        end
    end

    // Scoreboard: every presented beat must match the oldest expected beat.
    beat_t q0[$];
    beat_t q1[$];
    beat_t exp0, exp1;

    always @(negedge clk) begin
        if (out_valid0 === 1'b1) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL beat0_unexpected: got data %h idx %0d last %b, want no beat",
                         out_data0, out_index0, out_last0);
            end else begin
                exp0 = q0.pop_front();
                if ({out_data0, out_index0, out_last0} !== exp0) begin
                    errors++;
                    $display("FAIL beat0: got %h/%0d/%b want %h/%0d/%b", out_data0, out_index0,
                             out_last0, exp0.data, exp0.idx, exp0.last);
                end
            end
        end
        if (out_valid1 === 1'b1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL beat1_unexpected: got data %h idx %0d last %b, want no beat",
                         out_data1, out_index1, out_last1);
            end else begin
                exp1 = q1.pop_front();
                if ({out_data1, out_index1, out_last1} !== exp1) begin
                    errors++;
                    $display("FAIL beat1: got %h/%0d/%b want %h/%0d/%b", out_data1, out_index1,
                             out_last1, exp1.data, exp1.idx, exp1.last);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        #1;
        checks++;
        if ({req_ready0, d0.acquire, d0.read, d0.write, done0, out_valid0} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 100000",
                     {req_ready0, d0.acquire, d0.read, d0.write, done0, out_valid0});
        end
        checks++;
        if ({d0.burstcnt, d0.byteenable, d0.addr, d0.wdata} !== '0) begin
            errors++;
            $display("FAIL reset_fields: got bc %h be %h addr %h wdata %h want all 0",
                     d0.burstcnt, d0.byteenable, d0.addr, d0.wdata);
        end
    endtask

    // Full line read on instance 0 with an always-ready memory.
    task automatic run_read(input logic [31:0] a, input logic [31:0] exp_addr,
                            input logic [63:0] base);
        step();
        rd_req0 = 1'b1;
        rd_addr0 = a;
        #1;
        checks++;
        if (req_ready0 !== 1'b1) begin
            errors++;
            $display("FAIL rd_req_ready: got %b want 1", req_ready0);
        end
        step();
        rd_req0 = 1'b0;
        #1;
        checks++;
        if ({d0.read, d0.acquire, d0.write, req_ready0} !== 4'b1100
            || d0.addr !== exp_addr || d0.burstcnt !== 8'd4) begin
            errors++;
            $display("FAIL rd_cmd: got rd/acq/wr/rdy %b addr %h bc %0d want 1100 addr %h bc 4",
                     {d0.read, d0.acquire, d0.write, req_ready0}, d0.addr, d0.burstcnt,
                     exp_addr);
        end
        step();
        #1;
        checks++;
        if ({d0.read, d0.acquire} !== 2'b01) begin
            errors++;
            $display("FAIL rd_data_strobes: got rd/acq %b want 01", {d0.read, d0.acquire});
        end
        for (int i = 0; i < 4; i++) begin
            rdr0 = 1'b1;
            rdata0 = base + 64'(i);
            q0.push_back('{data: base + 64'(i), idx: 2'(i), last: (i == 3)});
            #1;
            checks++;
            if (done0 !== (i == 3)) begin
                errors++;
                $display("FAIL rd_done beat %0d: got %b want %b", i, done0, (i == 3));
            end
            step();
        end
        rdr0 = 1'b0;
        #1;
        checks++;
        if ({d0.acquire, req_ready0, d0.read} !== 3'b000) begin
            errors++;
            $display("FAIL rd_release: got acq/rdy/rd %b want 000",
                     {d0.acquire, req_ready0, d0.read});
        end
        step();
        #1;
        checks++;
        if (req_ready0 !== 1'b1) begin
            errors++;
            $display("FAIL rd_idle_ready: got %b want 1", req_ready0);
        end
    endtask

    task automatic test_read_line();
        run_read(32'h1003, 32'h1000, 64'hA0);
    endtask

    task automatic test_write();
        step();
        wr_req0 = 1'b1;
        wr_addr0 = 32'h20;
        wr_data0 = 64'h1122334455667788;
        wr_be0 = 8'h0F;
        busy_mem = 1'b1;
        step();
        wr_req0 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            busy_mem = (c < 3);
            #1;
            checks++;
            if ({d0.write, d0.read, d0.acquire, done0} !== {3'b101, c == 3}
                || d0.addr !== 32'h20 || d0.wdata !== 64'h1122334455667788
                || d0.byteenable !== 8'h0F || d0.burstcnt !== 8'd1) begin
                errors++;
                $display("FAIL wr_cmd cycle %0d: got wr/rd/acq/done %b addr %h wd %h be %h bc %0d",
                         c, {d0.write, d0.read, d0.acquire, done0}, d0.addr, d0.wdata,
                         d0.byteenable, d0.burstcnt);
            end
            step();
        end
        busy_mem = 1'b0;
        #1;
        checks++;
        if ({d0.write, d0.acquire, req_ready0, d0.byteenable, d0.burstcnt} !== '0) begin
            errors++;
            $display("FAIL wr_release: got wr/acq/rdy %b be %h bc %0d want all 0",
                     {d0.write, d0.acquire, req_ready0}, d0.byteenable, d0.burstcnt);
        end
        step();
        #1;
        checks++;
        if (req_ready0 !== 1'b1) begin
            errors++;
            $display("FAIL wr_idle_ready: got %b want 1", req_ready0);
        end
    endtask

    task automatic test_simultaneous();
        step();
        rd_req0 = 1'b1;
        rd_addr0 = 32'h2040;
        wr_req0 = 1'b1;
        wr_addr0 = 32'h44;
        wr_data0 = 64'hCAFEF00D12345678;
        wr_be0 = 8'hF0;
        step();
        rd_req0 = 1'b0;
        #1;
        checks++;
        if ({d0.read, d0.write} !== 2'b10 || d0.addr !== 32'h2040) begin
            errors++;
            $display("FAIL sim_read_first: got rd/wr %b addr %h want 10 addr 2040",
                     {d0.read, d0.write}, d0.addr);
        end
        step();
        for (int i = 0; i < 4; i++) begin
            rdr0 = 1'b1;
            rdata0 = 64'hB0 + 64'(i);
            q0.push_back('{data: 64'hB0 + 64'(i), idx: 2'(i), last: (i == 3)});
            step();
        end
        rdr0 = 1'b0;
        #1;
        checks++;
        if ({req_ready0, d0.write, d0.acquire} !== 3'b000) begin
            errors++;
            $display("FAIL sim_release: got rdy/wr/acq %b want 000",
                     {req_ready0, d0.write, d0.acquire});
        end
        step();
        step();
        wr_req0 = 1'b0;
        #1;
        checks++;
        if ({d0.write, done0} !== 2'b11 || d0.addr !== 32'h44
            || d0.wdata !== 64'hCAFEF00D12345678 || d0.byteenable !== 8'hF0) begin
            errors++;
            $display("FAIL sim_write: got wr/done %b addr %h wd %h be %h want 11 44 cafef00d12345678 f0",
                     {d0.write, done0}, d0.addr, d0.wdata, d0.byteenable);
        end
        step();
        step();
    endtask

    task automatic test_reset_mid_burst();
        step();
        rd_req0 = 1'b1;
        rd_addr0 = 32'h3000;
        step();
        rd_req0 = 1'b0;
        step();
        for (int i = 0; i < 2; i++) begin
            rdr0 = 1'b1;
            rdata0 = 64'h90 + 64'(i);
            q0.push_back('{data: 64'h90 + 64'(i), idx: 2'(i), last: 1'b0});
            step();
        end
        rdr0 = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rdr0 = 1'b1;
            rdata0 = 64'h92 + 64'(k);
            #1;
            checks++;
            if ({out_valid0, done0, d0.acquire, d0.read, req_ready0} !== 5'b00001) begin
                errors++;
                $display("FAIL abort_beat %0d: got vld/done/acq/rd/rdy %b want 00001", k,
                         {out_valid0, done0, d0.acquire, d0.read, req_ready0});
            end
            step();
        end
        rdr0 = 1'b0;
        run_read(32'h3000, 32'h3000, 64'hC0);
    endtask

    task automatic test_stray_beat();
        for (int k = 0; k < 2; k++) begin
            rdr0 = 1'b1;
            rdata0 = 64'hDEAD;
            #1;
            checks++;
            if (out_valid0 !== 1'b0) begin
                errors++;
                $display("FAIL stray_beat: got out_valid %b want 0", out_valid0);
            end
            step();
        end
        rdr0 = 1'b0;
        run_read(32'h4B, 32'h48, 64'hF0);
    endtask

    task automatic test_back_to_back_arb();
        int owner = -1;
        int beat = 0;
        int rel_host = -1;
        int ndone = 0;
        use_arb = 1'b1;
        step();
        rd_req0 = 1'b1;
        rd_addr0 = 32'h100;
        rd_req1 = 1'b1;
        rd_addr1 = 32'h200;
        step();
        rd_req0 = 1'b0;
        rd_req1 = 1'b0;
        for (int cyc = 0; cyc < 80 && ndone < 2; cyc++) begin
            rdr0 = 1'b0;
            rdr1 = 1'b0;
            if (rel_host >= 0) begin
                checks++;
                if ((rel_host == 0 ? d0.acquire : d1.acquire) !== 1'b0) begin
                    errors++;
                    $display("FAIL arb_release host %0d: got acquire 1 want 0", rel_host);
                end
                rel_host = -1;
            end
            if (owner == 0) begin
                rdr0 = 1'b1;
                rdata0 = 64'hD0 + 64'(beat);
                q0.push_back('{data: 64'hD0 + 64'(beat), idx: 2'(beat), last: (beat == 3)});
            end else if (owner == 1) begin
                rdr1 = 1'b1;
                rdata1 = 64'hE0 + 64'(beat);
                q1.push_back('{data: 64'hE0 + 64'(beat), idx: 2'(beat), last: (beat == 3)});
            end
            #1;
            if (owner >= 0) begin
                checks++;
                if ((owner == 0 ? done0 : done1) !== (beat == 3)) begin
                    errors++;
                    $display("FAIL arb_done host %0d beat %0d: got %b want %b", owner, beat,
                             (owner == 0 ? done0 : done1), (beat == 3));
                end
                if (beat == 3) begin
                    ndone++;
                    rel_host = owner;
                    owner = -1;
                    beat = 0;
                end else begin
                    beat++;
                end
            end else if (d0.read === 1'b1 && d0.busy === 1'b0) begin
                owner = 0;
            end else if (d1.read === 1'b1 && d1.busy === 1'b0) begin
                owner = 1;
            end
            step();
        end
        rdr0 = 1'b0;
        rdr1 = 1'b0;
        checks++;
        if (ndone != 2) begin
            errors++;
            $display("FAIL arb_completions: got %0d want 2", ndone);
        end
        repeat (3) step();
        use_arb = 1'b0;
    endtask

    initial begin
        test_reset();
        test_read_line();
        test_write();
        test_simultaneous();
        test_reset_mid_burst();
        test_stray_beat();
        test_back_to_back_arb();
        repeat (2) step();
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL beats_missing: got %0d/%0d pending want 0/0", q0.size(), q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
